tx_frame_scheduler: RTL and testbench

//  Sequences one transmit frame into the turbo-encoder/pulse-filter chain: preamble, payload pulled from source, encoder-flush tail, idle guard.

---
 rtl/tx_sched_pkg.sv | 20 ++
 rtl/tx_bit_pacer.sv | 37 +++
 rtl/tx_frame_scheduler.sv | 160 ++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit frame scheduler: FSM states and payload whitening LFSR.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    PAY   = 3'd2,
    TAIL  = 3'd3,
    GUARD = 3'd4
  } state_e;

  localparam logic [6:0] LFSR_SEED = 7'h7F;
  // x^7 + x^4 + 1: feedback from bits 6 and 3
  localparam logic [6:0] LFSR_TAPS = 7'b100_1000;

  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tx_bit_pacer.sv
// Bit-period divider: strobe on the first clock and last on the final clock of each BIT_DIV-clock period.
module tx_bit_pacer #(
  parameter int BIT_DIV = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic strobe_o,
  output logic last_o
);

  localparam int DW = $clog2(BIT_DIV);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (clr_i) begin
      div_d = '0;
    end else if (en_i) begin
      div_d = (div_q == DW'(BIT_DIV - 1)) ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign strobe_o = en_i && (div_q == '0);
  assign last_o   = en_i && (div_q == DW'(BIT_DIV - 1));

endmodule

// File: rtl/tx_frame_scheduler.sv
// Frame sequencer feeding the transmitter: preamble, paced payload, encoder-flush tail, idle guard.
// Optional payload whitening with TX_SCHED_SCRAMBLE_EN.
module tx_frame_scheduler
  import tx_sched_pkg::*;
#(
  parameter int          BIT_DIV   = 8,
  parameter int          PRE_LEN   = 16,
  parameter logic [31:0] PREAMBLE  = 32'h0000_F0A5,
  parameter int          FRAME_LEN = 1024,
  parameter int          TAIL_LEN  = 3,
  parameter int          GUARD_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        src_data_i,
  input  logic        src_valid_i,
  output logic        src_ready_o,
  output logic        tx_in_o,
  output logic        tx_enable_o,
  output logic        tx_strobe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        underrun_o,
  output logic [15:0] frame_cnt_o
);

  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  state_e        state_q;
  logic [15:0]   bit_cnt_q;
  logic [GW-1:0] guard_q;
  logic          tx_q;
  logic          abort_q;
  logic          done_q;
  logic          underrun_q;
  logic [15:0]   frame_cnt_q;

  logic   active, start_acc, strobe, last;
  logic   bit_now, last_bit, pay_bit;
  logic [4:0] pre_idx;
  state_e nxt_state;

  assign active    = (state_q == PRE) || (state_q == PAY) || (state_q == TAIL);
  assign start_acc = (state_q == IDLE) && start_i && !abort_i;

  tx_bit_pacer #(.BIT_DIV(BIT_DIV)) u_pacer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (start_acc),
    .en_i     (active),
    .strobe_o (strobe),
    .last_o   (last)
  );

`ifdef TX_SCHED_SCRAMBLE_EN
  logic [6:0] lfsr_q;
  assign pay_bit = src_data_i ^ lfsr_q[6];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else if (start_acc) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q == PAY && strobe) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end
`else
  assign pay_bit = src_data_i;
`endif

  assign pre_idx = 5'(PRE_LEN - 1) - bit_cnt_q[4:0];

  always_comb begin
    bit_now   = 1'b0;
    last_bit  = 1'b0;
    nxt_state = GUARD;
    case (state_q)
      PRE: begin
        bit_now   = PREAMBLE[pre_idx];
        last_bit  = (bit_cnt_q == 16'(PRE_LEN - 1));
        nxt_state = PAY;
      end
      PAY: begin
        // a starved bit is sent as zero but still occupies its slot
        bit_now   = src_valid_i & pay_bit;
        last_bit  = (bit_cnt_q == 16'(FRAME_LEN - 1));
        nxt_state = (TAIL_LEN == 0) ? GUARD : TAIL;
      end
      TAIL: begin
        last_bit  = (bit_cnt_q == 16'(TAIL_LEN - 1));
        nxt_state = GUARD;
      end
      default: ;
    endcase
    if (abort_q || abort_i) nxt_state = GUARD;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      guard_q     <= '0;
      tx_q        <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (strobe) tx_q <= bit_now;
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            state_q    <= PRE;
            bit_cnt_q  <= '0;
            abort_q    <= 1'b0;
            underrun_q <= 1'b0;
          end
        end
        PRE, PAY, TAIL: begin
          if (abort_i) abort_q <= 1'b1;
          if (state_q == PAY && strobe && !src_valid_i) underrun_q <= 1'b1;
          // abort only takes effect once the bit in flight has run its full period
          if (last) begin
            if (last_bit || abort_q || abort_i) begin
              state_q   <= nxt_state;
              bit_cnt_q <= '0;
              guard_q   <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 16'd1;
            end
          end
        end
        GUARD: begin
          if (guard_q == GW'(GUARD_CYC - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            if (!abort_q) frame_cnt_q <= frame_cnt_q + 16'd1;
          end else begin
            guard_q <= guard_q + GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_in_o     = active & (strobe ? bit_now : tx_q);
  assign tx_enable_o = active;
  assign tx_strobe_o = strobe;
  assign src_ready_o = (state_q == PAY) && strobe;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign underrun_o  = underrun_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with default parameters; payload expectations follow TX_SCHED_SCRAMBLE_EN.
module tb_tx_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, src_data, src_valid;
  logic        src_ready, tx_in, tx_enable, tx_strobe, busy, done, underrun;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  int   busy_n, en_n, ready_n, done_n, nstrobe;
  bit   fin;
  logic en207, en208;
  logic bits [0:1100];

`ifdef TX_SCHED_SCRAMBLE_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  always #5 clk = ~clk;

  tx_frame_scheduler #(
    .BIT_DIV(8), .PRE_LEN(16), .PREAMBLE(32'h0000_F0A5),
    .FRAME_LEN(1024), .TAIL_LEN(3), .GUARD_CYC(64)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .src_data_i  (src_data),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .tx_in_o     (tx_in),
    .tx_enable_o (tx_enable),
    .tx_strobe_o (tx_strobe),
    .busy_o      (busy),
    .done_o      (done),
    .underrun_o  (underrun),
    .frame_cnt_o (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge in IDLE; returns after done is seen or the budget expires.
  task automatic do_frame(input int abort_at, input int uv_lo, input int uv_hi, input logic d);
    busy_n = 0; en_n = 0; ready_n = 0; done_n = 0; nstrobe = 0; fin = 1'b0;
    en207 = 1'bx; en208 = 1'bx;
    for (int i = 0; i <= 1100; i++) bits[i] = 1'bx;
    src_data = d; src_valid = 1'b1; abort = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 9000 && !fin; c++) begin
      abort = (c == abort_at);
      if (c % 8 == 0) src_valid = !((c / 8 + 1) >= uv_lo && (c / 8 + 1) <= uv_hi);
      @(negedge clk);
      if (busy) busy_n++;
      if (tx_strobe) begin
        nstrobe++;
        if (tx_enable) en_n++;
        if (nstrobe <= 1100) bits[nstrobe] = tx_in;
      end
      if (src_ready) ready_n++;
      if (c == 207) en207 = tx_enable;
      if (c == 208) en208 = tx_enable;
      if (done) begin done_n++; fin = 1'b1; end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    check("frame_completed", {31'd0, fin}, 32'd1);
  endtask

  // Compare captured payload strobes against plain or whitened source data.
  task automatic check_payload(input string tag, input int uv_lo, input int uv_hi, input logic d);
    logic [6:0] lf;
    logic       e;
    int         errs;
    lf = 7'h7F;
    errs = 0;
    for (int p = 0; p < 1024; p++) begin
      e = (p + 17 >= uv_lo && p + 17 <= uv_hi) ? 1'b0 : (d ^ (SCR & lf[6]));
      if (bits[p + 17] !== e) errs++;
      lf = {lf[5:0], lf[6] ^ lf[3]};
    end
    check(tag, errs, 0);
  endtask

  logic [15:0] pre;
  logic [6:0]  first7;
  logic        d1;
  int          dn;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; src_data = 1'b0; src_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tx_enable", tx_enable, 0);
    check("rst_tx_in", tx_in, 0);
    check("rst_tx_strobe", tx_strobe, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1: clean frame; all-zero data when whitened so the LFSR shows through
    d1 = SCR ? 1'b0 : 1'b1;
    do_frame(-1, 0, 0, d1);
    check("f1_busy_clocks", busy_n, 8408);
    check("f1_enable_bits", en_n, 1043);
    check("f1_src_ready", ready_n, 1024);
    check("f1_done", done_n, 1);
    check("f1_frame_cnt", frame_cnt, 1);
    check("f1_underrun", underrun, 0);
    for (int k = 1; k <= 16; k++) pre[16 - k] = bits[k];
    check("f1_preamble", pre, 16'hF0A5);
    for (int k = 0; k < 7; k++) first7[6 - k] = bits[17 + k];
    check("f1_first7", first7, 7'h7F);
    check_payload("f1_payload", 0, 0, d1);
    check("f1_tail", {bits[1041], bits[1042], bits[1043]}, 3'b000);
    check("f1_idle_enable", tx_enable, 0);

    // Frame 2: source starves for strobes 20..21
    do_frame(-1, 20, 21, 1'b1);
    check("f2_starved_bits", {bits[20], bits[21]}, 2'b00);
    check_payload("f2_payload", 20, 21, 1'b1);
    check("f2_underrun", underrun, 1);
    check("f2_frame_cnt", frame_cnt, 2);
    check("f2_src_ready", ready_n, 1024);

    // Frame 3: abort on first clock of bit 25 (counting from 0)
    do_frame(200, 0, 0, 1'b1);
    check("f3_busy_clocks", busy_n, 272);
    check("f3_src_ready", ready_n, 10);
    check("f3_enable_bits", en_n, 26);
    check("f3_bit_held", en207, 1);
    check("f3_guard_start", en208, 0);
    check("f3_done", done_n, 1);
    check("f3_frame_cnt", frame_cnt, 2);
    check("f3_underrun_cleared", underrun, 0);

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_ignored", busy, 0);
    @(posedge clk); #1;

    // Reset in the middle of the payload
    src_valid = 1'b1; src_data = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_enable", tx_enable, 0);
    check("mid_rst_tx_in", tx_in, 0);
    check("mid_rst_src_ready", src_ready, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("mid_rst_no_done", dn, 0);
    check("mid_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
